// File: rtl/dac_spi_out_if.sv
// Bus bundle between the oscillator-sum source and the DAC SPI output stage.
// The slave modport is the DAC stage; master is whatever feeds it samples.
interface dac_spi_out_if;
    logic signed [15:0] sample_in;
    logic        [2:0]  gain_shift;
    logic               enable;
    logic               dac_sclk;
    logic               dac_sync_n;
    logic               dac_din;
    logic               busy;
    logic               frame_done;
    logic               overrun;
    logic               sat;

    modport master (
        output sample_in, gain_shift, enable,
        input  dac_sclk, dac_sync_n, dac_din, busy, frame_done, overrun, sat
    );

    modport slave (
        input  sample_in, gain_shift, enable,
        output dac_sclk, dac_sync_n, dac_din, busy, frame_done, overrun, sat
    );
endinterface

// File: rtl/dac_spi_out.sv
// Periodic sample capture, power-of-two gain, offset-binary conversion and 24-bit SPI framing
// for a single 16-bit DAC. Define DACOUT_SAT_EN to clamp (instead of wrap) the gained sample.
module dac_spi_out #(
    parameter int         SCLK_DIV      = 4,
    parameter int         FRAME_BITS    = 24,
    parameter logic [7:0] CTRL_BYTE     = 8'h00,
    parameter int         SAMPLE_PERIOD = 256
) (
    input  logic         clk,
    input  logic         reset,
    dac_spi_out_if.slave bus
);
    localparam int DATA_W  = 16;
    localparam int BIT_CYC = 2 * SCLK_DIV;
    localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int BW      = $clog2(FRAME_BITS);
    localparam int PW      = $clog2(SAMPLE_PERIOD);

    localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] SCLK_HALF = CW'(SCLK_DIV);
    localparam logic [BW-1:0] BIT_TOP   = BW'(FRAME_BITS - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [PW-1:0]         r_pcnt;
    logic [CW-1:0]         r_cyc, w_cyc_nxt, w_cyc_inc;
    logic [BW-1:0]         r_bit, w_bit_nxt;
    logic [FRAME_BITS-2:0] r_shreg, w_shreg_nxt;
    logic                  r_sclk, w_sclk_nxt;
    logic                  r_sync_n, w_sync_n_nxt;
    logic                  r_din, w_din_nxt;
    logic                  r_busy, r_done, r_overrun, w_ovr_nxt;
    logic                  w_due, w_bit_end, w_last_bit;
    logic [DATA_W-1:0]     w_code;
    logic [FRAME_BITS-1:0] w_frame;

`ifdef DACOUT_SAT_EN
    logic r_sat, w_clip;

    // Sign-extend to 23 bits, shift, clamp to the 16-bit range, then flip MSB to offset binary.
    function automatic logic [DATA_W:0] sat_code(input logic signed [DATA_W-1:0] s,
                                                 input logic [2:0] g);
        logic signed [22:0] v;
        logic [DATA_W-1:0]  c;
        logic               clip;
        v    = s;
        v    = v <<< g;
        clip = 1'b1;
        if (v > 23'sd32767)
            c = 16'h7FFF;
        else if (v < -23'sd32768)
            c = 16'h8000;
        else begin
            clip = 1'b0;
            c    = v[DATA_W-1:0];
        end
        return {clip, ~c[DATA_W-1], c[DATA_W-2:0]};
    endfunction

    assign {w_clip, w_code} = sat_code(bus.sample_in, bus.gain_shift);
    assign bus.sat          = r_sat;
`else
    // Only the low 16 bits of the shifted value survive, so a 16-bit shift is equivalent.
    function automatic logic [DATA_W-1:0] wrap_code(input logic [DATA_W-1:0] s,
                                                    input logic [2:0] g);
        logic [DATA_W-1:0] t;
        t = s << g;
        return {~t[DATA_W-1], t[DATA_W-2:0]};
    endfunction

    assign w_code  = wrap_code(bus.sample_in, bus.gain_shift);
    assign bus.sat = 1'b0;
`endif

    assign w_frame    = {CTRL_BYTE, w_code};
    assign w_due      = bus.enable && (r_pcnt == '0);
    assign w_bit_end  = (r_cyc == CYC_LAST);
    assign w_last_bit = (r_bit == '0);
    assign w_cyc_inc  = r_cyc + 1'b1;

    always_ff @(posedge clk) begin
        r_shreg <= w_shreg_nxt;
        if (reset) begin
            r_state   <= S_IDLE;
            r_pcnt    <= '0;
            r_cyc     <= '0;
            r_bit     <= '0;
            r_sclk    <= 1'b1;
            r_sync_n  <= 1'b1;
            r_din     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
`ifdef DACOUT_SAT_EN
            r_sat     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_pcnt    <= (!bus.enable || r_pcnt == PCNT_LAST) ? '0 : r_pcnt + 1'b1;
            r_cyc     <= w_cyc_nxt;
            r_bit     <= w_bit_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sync_n  <= w_sync_n_nxt;
            r_din     <= w_din_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            r_overrun <= w_ovr_nxt;
`ifdef DACOUT_SAT_EN
            r_sat     <= r_sat | (w_due && r_state == S_IDLE && w_clip);
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_due) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_bit_end && w_last_bit) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; SCLK rises with each new bit, falls mid-bit.
    always_comb begin
        w_cyc_nxt    = r_cyc;
        w_bit_nxt    = r_bit;
        w_shreg_nxt  = r_shreg;
        w_din_nxt    = r_din;
        w_sclk_nxt   = 1'b1;
        w_sync_n_nxt = 1'b1;
        w_ovr_nxt    = r_overrun | (w_due && r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_due) begin
                    w_cyc_nxt    = '0;
                    w_bit_nxt    = BIT_TOP;
                    w_shreg_nxt  = w_frame[FRAME_BITS-2:0];
                    w_din_nxt    = w_frame[FRAME_BITS-1];
                    w_sync_n_nxt = 1'b0;
                end
            end
            S_SHIFT: begin
                if (!w_bit_end) begin
                    w_cyc_nxt    = w_cyc_inc;
                    w_sclk_nxt   = (w_cyc_inc < SCLK_HALF);
                    w_sync_n_nxt = 1'b0;
                end else if (!w_last_bit) begin
                    w_cyc_nxt    = '0;
                    w_bit_nxt    = r_bit - 1'b1;
                    w_din_nxt    = r_shreg[FRAME_BITS-2];
                    w_shreg_nxt  = {r_shreg[FRAME_BITS-3:0], 1'b0};
                    w_sync_n_nxt = 1'b0;
                end else begin
                    w_din_nxt = 1'b0;
                end
            end
            default: w_din_nxt = 1'b0;
        endcase
    end

    assign bus.dac_sclk   = r_sclk;
    assign bus.dac_sync_n = r_sync_n;
    assign bus.dac_din    = r_din;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_dac_spi_out.sv
// Directed bench for dac_spi_out: framing, codes, spacing, overrun, mid-frame enable/reset.
// Expected codes follow the DACOUT_SAT_EN setting of the build.
module tb_dac_spi_out;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_out_if bus0 ();
    dac_spi_out_if bus1 ();

    dac_spi_out #(.SCLK_DIV(4), .FRAME_BITS(24), .CTRL_BYTE(8'h00), .SAMPLE_PERIOD(256)) dut (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    dac_spi_out #(.SCLK_DIV(4), .FRAME_BITS(24), .CTRL_BYTE(8'h00), .SAMPLE_PERIOD(100)) dut_ov (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // action 1: drop enable and disturb inputs at bit 10; action 2: assert reset at bit 10.
    task automatic get_frame(input int action, output logic [23:0] fr, output int wait_n,
                             output int start_cyc, output bit aborted);
        int shape_err;
        int b;
        int c;
        shape_err = 0;
        fr        = '0;
        wait_n    = 0;
        start_cyc = 0;
        aborted   = 1'b0;
        for (int t = 1; t <= 400; t++) begin
            @(negedge clk);
            if (bus0.dac_sync_n === 1'b0) begin
                wait_n = t;
                break;
            end
        end
        if (wait_n == 0) begin
            chk("frame_start_timeout", {31'd0, bus0.dac_sync_n}, 32'd0);
            return;
        end
        start_cyc = cyc;
        for (int i = 0; i < 192; i++) begin
            b = 23 - i / 8;
            c = i % 8;
            if (i > 0) @(negedge clk);
            if (action == 2 && i == 104) begin
                reset = 1'b1;
                @(negedge clk);
                chk("rst_mid_sync_n", {31'd0, bus0.dac_sync_n}, 32'd1);
                chk("rst_mid_sclk",   {31'd0, bus0.dac_sclk},   32'd1);
                chk("rst_mid_busy",   {31'd0, bus0.busy},       32'd0);
                chk("rst_mid_din",    {31'd0, bus0.dac_din},    32'd0);
                aborted = 1'b1;
                return;
            end
            if (action == 1 && i == 104) begin
                bus0.enable     = 1'b0;
                bus0.sample_in  = 16'h5555;
                bus0.gain_shift = 3'd7;
            end
            if (bus0.dac_sync_n !== 1'b0 || bus0.busy !== 1'b1 || bus0.dac_sclk !== (c < 4))
                shape_err++;
            if (c == 0) fr[b] = bus0.dac_din;
            else if (bus0.dac_din !== fr[b]) shape_err++;
        end
        chk("frame_shape", shape_err, 0);
        @(negedge clk);
        chk("done_pulse", {29'd0, bus0.dac_sync_n, bus0.dac_sclk, bus0.frame_done}, 32'd7);
        @(negedge clk);
        chk("done_clear", {30'd0, bus0.frame_done, bus0.busy}, 32'd0);
    endtask

    initial begin
        logic [23:0] fr;
        int          w;
        int          s1;
        int          s2;
        bit          ab;
        int          err;
        int          falls;
        int          lows;
        int          dones;
        logic        prev;
        logic        ov100;
        logic        ov101;

        reset = 1'b1;
        bus0.enable = 1'b0; bus0.sample_in = 16'h0000; bus0.gain_shift = 3'd0;
        bus1.enable = 1'b0; bus1.sample_in = 16'h0000; bus1.gain_shift = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk",    {31'd0, bus0.dac_sclk},   32'd1);
        chk("rst_sync_n",  {31'd0, bus0.dac_sync_n}, 32'd1);
        chk("rst_din",     {31'd0, bus0.dac_din},    32'd0);
        chk("rst_busy",    {31'd0, bus0.busy},       32'd0);
        chk("rst_done",    {31'd0, bus0.frame_done}, 32'd0);
        chk("rst_overrun", {31'd0, bus0.overrun},    32'd0);
        chk("rst_sat",     {31'd0, bus0.sat},        32'd0);

        reset = 1'b0;
        err = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus0.dac_sync_n !== 1'b1 || bus0.dac_sclk !== 1'b1 || bus0.busy !== 1'b0)
                err++;
        end
        chk("idle_disabled", err, 0);

        bus0.enable = 1'b1;
        get_frame(0, fr, w, s1, ab);
        chk("zero_latency", w, 1);
        chk("zero_frame", {8'd0, fr}, 32'h008000);

        bus0.sample_in = 16'hFFFF;
        get_frame(0, fr, w, s2, ab);
        chk("capture_spacing", s2 - s1, 256);
        chk("neg1_frame", {8'd0, fr}, 32'h007FFF);

        bus0.sample_in = 16'h7FFF;
        get_frame(0, fr, w, s1, ab);
        chk("maxpos_frame", {8'd0, fr}, 32'h00FFFF);

        bus0.sample_in = 16'h8000;
        get_frame(0, fr, w, s1, ab);
        chk("maxneg_frame", {8'd0, fr}, 32'h000000);

        bus0.sample_in = 16'h3000; bus0.gain_shift = 3'd2;
        get_frame(0, fr, w, s1, ab);
`ifdef DACOUT_SAT_EN
        chk("gain_frame", {8'd0, fr}, 32'h00FFFF);
        chk("gain_sat", {31'd0, bus0.sat}, 32'd1);
`else
        chk("gain_frame", {8'd0, fr}, 32'h004000);
        chk("gain_sat", {31'd0, bus0.sat}, 32'd0);
`endif
        chk("no_overrun", {31'd0, bus0.overrun}, 32'd0);

        bus0.sample_in = 16'h1234; bus0.gain_shift = 3'd0;
        get_frame(1, fr, w, s1, ab);
        chk("en_drop_frame", {8'd0, fr}, 32'h009234);
        err = 0;
        repeat (600) begin
            @(negedge clk);
            if (bus0.dac_sync_n !== 1'b1 || bus0.busy !== 1'b0) err++;
        end
        chk("disabled_quiet", err, 0);

        bus0.enable = 1'b1;
        get_frame(2, fr, w, s1, ab);
        chk("reenable_latency", w, 1);
        chk("reset_aborted", {31'd0, ab}, 32'd1);
        chk("rst2_overrun", {31'd0, bus0.overrun}, 32'd0);
        chk("rst2_sat", {31'd0, bus0.sat}, 32'd0);

        reset = 1'b0;
        get_frame(0, fr, w, s1, ab);
        chk("after_rst_latency", w, 1);
`ifdef DACOUT_SAT_EN
        chk("gain7_frame", {8'd0, fr}, 32'h00FFFF);
`else
        chk("gain7_frame", {8'd0, fr}, 32'h002A80);
`endif
        bus0.enable = 1'b0;

        bus1.enable = 1'b1;
        falls = 0; lows = 0; dones = 0; prev = 1'b1; ov100 = 1'bx; ov101 = 1'bx;
        for (int j = 1; j <= 600; j++) begin
            @(negedge clk);
            if (prev === 1'b1 && bus1.dac_sync_n === 1'b0) falls++;
            if (bus1.dac_sync_n === 1'b0) lows++;
            if (bus1.frame_done === 1'b1) dones++;
            if (j == 100) ov100 = bus1.overrun;
            if (j == 101) ov101 = bus1.overrun;
            prev = bus1.dac_sync_n;
        end
        chk("ovr_frames", falls, 3);
        chk("ovr_low_cycles", lows, 576);
        chk("ovr_done_pulses", dones, 3);
        chk("ovr_before", {31'd0, ov100}, 32'd0);
        chk("ovr_rise", {31'd0, ov101}, 32'd1);
        chk("ovr_sticky", {31'd0, bus1.overrun}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
